// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer-to-transmitter word handshake.
//   tx_valid : producer has a word on tx_data
//   tx_ready : transmitter FIFO can accept a word
//   tx_data  : payload word, PAYLOAD_BITS wide
// master = producer side, slave = transmitter side.
interface uart_tx_fifo_if #(
  parameter int PAYLOAD_BITS = 8
) ();
  logic                    tx_valid;
  logic                    tx_ready;
  logic [PAYLOAD_BITS-1:0] tx_data;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an input FIFO and per-frame runtime
// framing (bit period, parity mode, stop-bit count). Frames are start bit,
// PAYLOAD_BITS data bits LSB first, optional parity, then 1 or 2 stop bits.
// Consecutive queued words go out back to back with no idle gap.
// Ports:
//   clk              : single clock
//   tx_reset         : asynchronous, active-high reset
//   bus              : tx_valid / tx_ready / tx_data word handshake (slave)
//   cfg_clks_per_bit : clocks per bit; 0 and 1 behave as 2
//   cfg_parity       : 00/11 none, 01 even, 10 odd
//   cfg_two_stop     : 1 selects two stop bits
//   fifo_level       : words queued, not counting the frame in flight
//   tx_busy          : frame in progress
//   tx_done          : one-cycle pulse after the last stop-bit cycle
//   tx_serial        : serial line, idle high
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int DIV_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             tx_reset,
  uart_tx_fifo_if.slave                    bus,
  input  logic [DIV_WIDTH-1:0]             cfg_clks_per_bit,
  input  logic [1:0]                       cfg_parity,
  input  logic                             cfg_two_stop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             tx_busy,
  output logic                             tx_done,
  output logic                             tx_serial
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(PAYLOAD_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
  endfunction

  // Even parity is the XOR of the data bits; odd is its inverse.
  function automatic logic parity_of(input logic [PAYLOAD_BITS-1:0] d,
                                     input logic [1:0] mode);
    return (^d) ^ (mode == 2'b10);
  endfunction

  logic [PAYLOAD_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic                    push;
  logic                    pop;
  logic                    fifo_nonempty;

  logic [2:0]              state;
  logic [DIV_WIDTH-1:0]    cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [IDX_W-1:0]        nxt_idx;
  logic                    stop_second;
  logic                    bit_end;
  logic                    last_stop;

  // Frame registers, loaded at the pop edge so cfg changes only affect later frames.
  logic [PAYLOAD_BITS-1:0] frame_data;
  logic [DIV_WIDTH-1:0]    div_q;
  logic                    par_en;
  logic                    par_bit;
  logic                    two_stop_q;

  assign bus.tx_ready  = (fifo_level < LVL_W'(FIFO_DEPTH));
  assign push          = bus.tx_valid && bus.tx_ready;
  assign fifo_nonempty = (fifo_level != '0);
  assign bit_end       = (cnt == div_q - DIV_WIDTH'(1));
  assign last_stop     = !two_stop_q || stop_second;
  assign nxt_idx       = bit_idx + IDX_W'(1);
  // Pop on an idle FSM, or exactly at the end of the final stop bit so the
  // next start bit follows with no gap.
  assign pop = fifo_nonempty &&
               ((state == S_IDLE) || ((state == S_STOP) && bit_end && last_stop));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.tx_data;
  end

  always_ff @(posedge clk or posedge tx_reset) begin
    if (tx_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      frame_data <= fifo_mem[rd_ptr];
      div_q      <= clamp_div(cfg_clks_per_bit);
      par_en     <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit    <= parity_of(fifo_mem[rd_ptr], cfg_parity);
      two_stop_q <= cfg_two_stop;
    end
  end

  always_ff @(posedge clk or posedge tx_reset) begin
    if (tx_reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      stop_second <= 1'b0;
      tx_serial   <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (pop) begin
            state     <= S_START;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt       <= '0;
            bit_idx   <= '0;
            state     <= S_DATA;
            tx_serial <= frame_data[0];
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == LAST_IDX) begin
              stop_second <= 1'b0;
              if (par_en) begin
                state     <= S_PARITY;
                tx_serial <= par_bit;
              end else begin
                state     <= S_STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              bit_idx   <= nxt_idx;
              tx_serial <= frame_data[nxt_idx];
            end
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cnt         <= '0;
            stop_second <= 1'b0;
            state       <= S_STOP;
            tx_serial   <= 1'b1;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (!last_stop) begin
              stop_second <= 1'b1;
            end else begin
              tx_done <= 1'b1;
              if (pop) begin
                state     <= S_START;
                tx_serial <= 1'b0;
              end else begin
                state     <= S_IDLE;
                tx_serial <= 1'b1;
                tx_busy   <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo. Each pushed word queues
// its expected frame description; a negedge monitor pops it when a start bit
// appears and checks the line cycle by cycle, then the tx_done pulse.
module tb_uart_tx_fifo;

  typedef struct {
    logic [7:0] data;
    logic [1:0] par;
    logic       two;
    int         div;
  } frame_t;

  logic        clk;
  logic        tx_reset;
  logic [15:0] cfg_clks_per_bit;
  logic [1:0]  cfg_parity;
  logic        cfg_two_stop;
  logic [2:0]  fifo_level;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_serial;

  uart_tx_fifo_if #(.PAYLOAD_BITS(8)) tx_if ();

  uart_tx_fifo #(.PAYLOAD_BITS(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk              (clk),
    .tx_reset         (tx_reset),
    .bus              (tx_if),
    .cfg_clks_per_bit (cfg_clks_per_bit),
    .cfg_parity       (cfg_parity),
    .cfg_two_stop     (cfg_two_stop),
    .fifo_level       (fifo_level),
    .tx_busy          (tx_busy),
    .tx_done          (tx_done),
    .tx_serial        (tx_serial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  frame_t exp_q[$];
  bit     line_q[$];
  bit     in_frame = 0;
  bit     done_due = 0;
  int     cyc = 0;
  int     last_end = -10;
  int     start_cyc = 0;
  int     last_len = 0;
  int     done_count = 0;
  int     start_count = 0;
  int     b2b_count = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Monitor: scoreboard consumer.
  always @(negedge clk) begin
    cyc++;
    if (tx_reset) begin
      in_frame = 0;
      done_due = 0;
      line_q.delete();
    end else begin
      if (done_due) begin
        done_due = 0;
        chk("done_pulse", {31'd0, tx_done}, 32'd1);
        chk("busy_at_done", {31'd0, tx_busy}, {31'd0, ~tx_serial});
        last_len = cyc - start_cyc;
        done_count++;
      end else begin
        chk("done_low", {31'd0, tx_done}, 32'd0);
      end
      if (!in_frame) begin
        if (tx_serial === 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_start", {31'd0, tx_serial}, 32'd1);
          end else begin
            frame_t f;
            int d;
            f = exp_q.pop_front();
            d = (f.div < 2) ? 2 : f.div;
            repeat (d) line_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (d) line_q.push_back(f.data[i]);
            if (f.par == 2'b01) repeat (d) line_q.push_back(^f.data);
            else if (f.par == 2'b10) repeat (d) line_q.push_back(~^f.data);
            repeat (d * (f.two ? 2 : 1)) line_q.push_back(1'b1);
            in_frame = 1;
            if (start_count > 0 && cyc == last_end + 1) b2b_count++;
            start_count++;
            start_cyc = cyc;
          end
        end else begin
          chk("busy_idle", {31'd0, tx_busy}, 32'd0);
        end
      end
      if (in_frame) begin
        bit e;
        e = line_q.pop_front();
        chk("serial_bit", {31'd0, tx_serial}, {31'd0, e});
        chk("busy_frame", {31'd0, tx_busy}, 32'd1);
        if (line_q.size() == 0) begin
          in_frame = 0;
          done_due = 1;
          last_end = cyc;
        end
      end
    end
  end

  // Push one word as soon as tx_ready allows; queue its expected frame.
  task automatic push_word(input logic [7:0] d, input logic [1:0] par,
                           input logic two, input int div);
    int waitc;
    frame_t f;
    waitc = 0;
    @(negedge clk);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = d;
    while (tx_if.tx_ready !== 1'b1 && waitc < 2000) begin
      @(negedge clk);
      waitc++;
    end
    chk("push_timeout", {31'd0, (waitc < 2000)}, 32'd1);
    f.data = d; f.par = par; f.two = two; f.div = div;
    exp_q.push_back(f);
    @(posedge clk);
    #1;
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame || done_due || tx_busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, (n < budget)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int dc0;
    int bb0;
    tx_reset = 1'b1;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data = 8'h00;
    cfg_clks_per_bit = 16'd4;
    cfg_parity = 2'b00;
    cfg_two_stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_serial", {31'd0, tx_serial}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_ready", {31'd0, tx_if.tx_ready}, 32'd1);
    #2 tx_reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte, D=4, no parity, one stop bit.
    dc0 = done_count;
    push_word(8'hA5, 2'b00, 1'b0, 4);
    chk("start_level_n", {29'd0, fifo_level}, 32'd1);
    chk("start_serial_n", {31'd0, tx_serial}, 32'd1);
    @(posedge clk); #1;
    chk("start_level_n1", {29'd0, fifo_level}, 32'd0);
    chk("start_serial_n1", {31'd0, tx_serial}, 32'd0);
    chk("start_busy_n1", {31'd0, tx_busy}, 32'd1);
    wait_idle(500);
    chk("single_len", last_len, 32'd40);
    chk("single_done_cnt", done_count - dc0, 32'd1);

    // Parity modes, D=2, two stop bits.
    cfg_clks_per_bit = 16'd2;
    cfg_two_stop = 1'b1;
    cfg_parity = 2'b01;
    push_word(8'h07, 2'b01, 1'b1, 2);
    wait_idle(500);
    chk("even_len", last_len, 32'd24);
    cfg_parity = 2'b10;
    push_word(8'h07, 2'b10, 1'b1, 2);
    wait_idle(500);
    chk("odd_len", last_len, 32'd24);

    // FIFO full and back-to-back, D=2, no parity, one stop bit.
    cfg_parity = 2'b00;
    cfg_two_stop = 1'b0;
    dc0 = done_count;
    bb0 = b2b_count;
    push_word(8'h11, 2'b00, 1'b0, 2);
    push_word(8'h22, 2'b00, 1'b0, 2);
    push_word(8'h33, 2'b00, 1'b0, 2);
    push_word(8'h44, 2'b00, 1'b0, 2);
    push_word(8'h55, 2'b00, 1'b0, 2);
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    chk("full_ready", {31'd0, tx_if.tx_ready}, 32'd0);
    push_word(8'h66, 2'b00, 1'b0, 2);
    wait_idle(1000);
    chk("b2b_done_cnt", done_count - dc0, 32'd6);
    chk("b2b_no_gap", b2b_count - bb0, 32'd5);

    // Mid-frame configuration change, D=4.
    cfg_clks_per_bit = 16'd4;
    push_word(8'h3C, 2'b00, 1'b0, 4);
    push_word(8'h81, 2'b01, 1'b0, 4);
    repeat (10) @(negedge clk);
    cfg_parity = 2'b01;
    wait_idle(1000);
    chk("cfgchg_len", last_len, 32'd44);
    cfg_parity = 2'b00;

    // Divisor clamp: 0 and 1 both give 2-cycle bits.
    cfg_clks_per_bit = 16'd0;
    push_word(8'h55, 2'b00, 1'b0, 0);
    wait_idle(500);
    chk("clamp0_len", last_len, 32'd20);
    cfg_clks_per_bit = 16'd1;
    push_word(8'hAA, 2'b00, 1'b0, 1);
    wait_idle(500);
    chk("clamp1_len", last_len, 32'd20);

    // Asynchronous reset during DATA with two words queued.
    cfg_clks_per_bit = 16'd4;
    push_word(8'hF0, 2'b00, 1'b0, 4);
    push_word(8'h0F, 2'b00, 1'b0, 4);
    push_word(8'h96, 2'b00, 1'b0, 4);
    chk("pre_rst_level", {29'd0, fifo_level}, 32'd2);
    repeat (8) @(negedge clk);
    #2 tx_reset = 1'b1;
    #1;
    chk("arst_serial", {31'd0, tx_serial}, 32'd1);
    chk("arst_busy", {31'd0, tx_busy}, 32'd0);
    chk("arst_level", {29'd0, fifo_level}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 tx_reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, tx_serial}, 32'd1);
    end
    push_word(8'h5A, 2'b00, 1'b0, 4);
    wait_idle(500);
    chk("post_rst_len", last_len, 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
